// File: rtl/fsb_node_trace_replay.sv
// Replays a ROM trace: SEND/RECV entries complete in their handshake cycle, so they add no latency.
// Replay holds while en_i=0, yumi_i=0 or v_i=0. The optional cycle counter (ops 4/5) is enabled with FSB_TRACE_CYCLE_CTR_EN.
module fsb_node_trace_replay #(
   parameter int ring_width_p     = 80,
   parameter int rom_addr_width_p = 23,
   parameter int counter_width_p  = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        en_i,
   input  logic                        v_i,
   input  logic [ring_width_p-1:0]     data_i,
   output logic                        ready_and_o,
   output logic                        v_o,
   output logic [ring_width_p-1:0]     data_o,
   input  logic                        yumi_i,
   output logic [rom_addr_width_p-1:0] rom_addr_o,
   input  logic [ring_width_p+3:0]     rom_data_i,
   output logic                        done_o,
   output logic                        error_o
);

   localparam logic [3:0] op_send     = 4'd0;
   localparam logic [3:0] op_recv     = 4'd1;
   localparam logic [3:0] op_done     = 4'd2;
   localparam logic [3:0] op_finish   = 4'd3;
   localparam logic [3:0] op_nop      = 4'd6;
`ifdef FSB_TRACE_CYCLE_CTR_EN
   localparam logic [3:0] op_ctr_init = 4'd4;
   localparam logic [3:0] op_ctr_wait = 4'd5;
`endif

   logic [3:0]                  op;
   logic [ring_width_p-1:0]     payload;
   logic [rom_addr_width_p-1:0] addr_q;
   logic                        done_q;
   logic                        error_q;
   logic                        advance;
   logic                        set_done;
   logic                        set_error;

   assign op      = rom_data_i[ring_width_p+3:ring_width_p];
   assign payload = rom_data_i[ring_width_p-1:0];

`ifdef FSB_TRACE_CYCLE_CTR_EN
   logic [counter_width_p-1:0] ctr_q;
   logic                       ctr_load;
   logic                       ctr_dec;
   logic                       ctr_zero;

   assign ctr_zero = (ctr_q == '0);
`endif

   always_comb begin
      v_o         = 1'b0;
      ready_and_o = 1'b0;
      advance     = 1'b0;
      set_done    = 1'b0;
      set_error   = 1'b0;
`ifdef FSB_TRACE_CYCLE_CTR_EN
      ctr_load    = 1'b0;
      ctr_dec     = 1'b0;
`endif
      if (en_i) begin
         case (op)
            op_send: begin
               v_o     = 1'b1;
               advance = yumi_i;
            end
            op_recv: begin
               ready_and_o = 1'b1;
               advance     = v_i;
               set_error   = v_i && (data_i != payload);
            end
            op_done, op_finish: begin
               set_done = 1'b1;
            end
`ifdef FSB_TRACE_CYCLE_CTR_EN
            op_ctr_init: begin
               ctr_load = 1'b1;
               advance  = 1'b1;
            end
            op_ctr_wait: begin
               ctr_dec = !ctr_zero;
               advance = ctr_zero;
            end
`endif
            op_nop: begin
               advance = 1'b1;
            end
            default: begin
               set_error = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         addr_q  <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         if (advance)
            addr_q <= addr_q + 1'b1;
         if (set_done)
            done_q <= 1'b1;
         if (set_error)
            error_q <= 1'b1;
      end
   end

`ifdef FSB_TRACE_CYCLE_CTR_EN
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         ctr_q <= '0;
      else if (ctr_load)
         ctr_q <= payload[counter_width_p-1:0];
      else if (ctr_dec)
         ctr_q <= ctr_q - 1'b1;
   end
`endif

   assign data_o     = payload;
   assign rom_addr_o = addr_q;
   assign done_o     = done_q;
   assign error_o    = error_q;

endmodule

// File: tb/tb_fsb_node_trace_replay.sv
module tb_fsb_node_trace_replay;
   localparam int W  = 80;
   localparam int AW = 23;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          en_i = 1'b0;
   logic          v_i = 1'b0;
   logic [W-1:0]  data_i = '0;
   logic          ready_and_o;
   logic          v_o;
   logic [W-1:0]  data_o;
   logic          yumi_i = 1'b0;
   logic [AW-1:0] rom_addr_o;
   logic [W+3:0]  rom_data_i;
   logic          done_o;
   logic          error_o;

   logic [W+3:0]  rom [0:15];
   int            n_chk = 0;
   int            n_fail = 0;

   always #5 clk_i = ~clk_i;

   assign rom_data_i = (rom_addr_o < 16) ? rom[rom_addr_o[3:0]] : {4'd2, {W{1'b0}}};

   fsb_node_trace_replay dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
      .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
      .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .done_o(done_o), .error_o(error_o)
   );

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] pay;
      logic         en;
      logic         v;
      logic [W-1:0] din;
      logic         yumi;
      logic         ev;
      logic         erdy;
      logic         eadv;
      logic         eerr;
      logic         edone;
   } vec_t;

   function automatic logic [W+3:0] ent(input logic [3:0] op, input logic [W-1:0] pay);
      return {op, pay};
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] pay, input logic en,
                               input logic v, input logic [W-1:0] din, input logic yumi,
                               input logic ev, input logic erdy, input logic eadv,
                               input logic eerr, input logic edone);
      vec_t t;
      t.op = op; t.pay = pay; t.en = en; t.v = v; t.din = din; t.yumi = yumi;
      t.ev = ev; t.erdy = erdy; t.eadv = eadv; t.eerr = eerr; t.edone = edone;
      return t;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = ent(4'd2, '0);
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      @(posedge clk_i);
      #1 reset_i = 1'b1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   vec_t vecs[$];
   logic [W-1:0] big;
   logic         ctr_en;

   initial begin
`ifdef FSB_TRACE_CYCLE_CTR_EN
      ctr_en = 1'b1;
`else
      ctr_en = 1'b0;
`endif
      big = {16'hBEEF, 64'h0123_4567_89AB_CDEF};
      clear_rom();

      #2;
      chk("reset rom_addr_o", 128'(rom_addr_o), 0);
      chk("reset done_o", 128'(done_o), 0);
      chk("reset error_o", 128'(error_o), 0);

      //                op     pay    en v  din           yumi ev rdy adv err done
      vecs.push_back(mk(4'd0, 80'h5, 1, 0, '0,           1,   1, 0,  1,  0,  0));
      vecs.push_back(mk(4'd0, big,   1, 0, '0,           0,   1, 0,  0,  0,  0));
      vecs.push_back(mk(4'd0, big,   0, 0, '0,           1,   0, 0,  0,  0,  0));
      vecs.push_back(mk(4'd1, big,   1, 1, big,          0,   0, 1,  1,  0,  0));
      vecs.push_back(mk(4'd1, big,   1, 1, big ^ 80'h1,  0,   0, 1,  1,  1,  0));
      vecs.push_back(mk(4'd1, 80'h3, 1, 1, {1'b1, 79'h3}, 0,  0, 1,  1,  1,  0));
      vecs.push_back(mk(4'd1, 80'h3, 1, 0, 80'h9,        0,   0, 1,  0,  0,  0));
      vecs.push_back(mk(4'd1, 80'h3, 0, 1, 80'h9,        0,   0, 0,  0,  0,  0));
      vecs.push_back(mk(4'd2, 80'h7, 1, 0, '0,           1,   0, 0,  0,  0,  1));
      vecs.push_back(mk(4'd3, 80'h7, 1, 1, '0,           0,   0, 0,  0,  0,  1));
      vecs.push_back(mk(4'd3, 80'h7, 0, 0, '0,           0,   0, 0,  0,  0,  0));
      vecs.push_back(mk(4'd6, big,   1, 0, '0,           0,   0, 0,  1,  0,  0));
      vecs.push_back(mk(4'd6, big,   0, 0, '0,           0,   0, 0,  0,  0,  0));
      vecs.push_back(mk(4'd7, 80'h1, 1, 1, '0,           1,   0, 0,  0,  1,  0));
      vecs.push_back(mk(4'hF, 80'h1, 1, 0, '0,           0,   0, 0,  0,  1,  0));
      vecs.push_back(mk(4'hF, 80'h1, 0, 0, '0,           0,   0, 0,  0,  0,  0));
      vecs.push_back(mk(4'd4, 80'h3, 1, 0, '0,           0,   0, 0,  ctr_en, !ctr_en, 0));
      vecs.push_back(mk(4'd5, 80'h0, 1, 0, '0,           0,   0, 0,  ctr_en, !ctr_en, 0));

      foreach (vecs[i]) begin
         clear_rom();
         rom[0] = ent(vecs[i].op, vecs[i].pay);
         en_i = vecs[i].en; v_i = vecs[i].v; data_i = vecs[i].din; yumi_i = vecs[i].yumi;
         do_reset();
         chk($sformatf("vec%0d v_o", i), 128'(v_o), 128'(vecs[i].ev));
         chk($sformatf("vec%0d ready_and_o", i), 128'(ready_and_o), 128'(vecs[i].erdy));
         chk($sformatf("vec%0d data_o", i), 128'(data_o), 128'(vecs[i].pay));
         tick();
         chk($sformatf("vec%0d rom_addr_o", i), 128'(rom_addr_o), vecs[i].eadv ? 1 : 0);
         chk($sformatf("vec%0d error_o", i), 128'(error_o), 128'(vecs[i].eerr));
         chk($sformatf("vec%0d done_o", i), 128'(done_o), 128'(vecs[i].edone));
      end

      // back-to-back SEND with yumi held, then DONE
      clear_rom();
      rom[0] = ent(4'd0, 80'h5); rom[1] = ent(4'd0, 80'h6);
      en_i = 1; v_i = 0; data_i = '0; yumi_i = 1;
      do_reset();
      chk("seq1 v_o c0", 128'(v_o), 1);
      chk("seq1 data_o c0", 128'(data_o), 5);
      tick();
      chk("seq1 addr c1", 128'(rom_addr_o), 1);
      chk("seq1 v_o c1", 128'(v_o), 1);
      chk("seq1 data_o c1", 128'(data_o), 6);
      chk("seq1 done c1", 128'(done_o), 0);
      tick();
      yumi_i = 0;
      chk("seq1 addr c2", 128'(rom_addr_o), 2);
      chk("seq1 v_o c2", 128'(v_o), 0);
      chk("seq1 done c2", 128'(done_o), 0);
      tick();
      chk("seq1 done c3", 128'(done_o), 1);
      tick();
      chk("seq1 addr c4", 128'(rom_addr_o), 2);

      // SEND stalled by consumer for five cycles
      clear_rom();
      rom[0] = ent(4'd0, 80'hA);
      yumi_i = 0;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("seq2 stall addr c%0d", c), 128'(rom_addr_o), 0);
         chk($sformatf("seq2 stall v_o c%0d", c), 128'(v_o), 1);
      end
      yumi_i = 1;
      tick();
      yumi_i = 0;
      chk("seq2 addr after yumi", 128'(rom_addr_o), 1);

      // RECV match then mismatch; error is sticky
      clear_rom();
      rom[0] = ent(4'd1, 80'h3); rom[1] = ent(4'd1, 80'h4);
      v_i = 1; data_i = 80'h3;
      do_reset();
      tick();
      chk("seq3 addr after match", 128'(rom_addr_o), 1);
      chk("seq3 error after match", 128'(error_o), 0);
      data_i = 80'h7;
      tick();
      v_i = 0;
      chk("seq3 addr after mismatch", 128'(rom_addr_o), 2);
      chk("seq3 error after mismatch", 128'(error_o), 1);
      tick(); tick();
      chk("seq3 error sticky", 128'(error_o), 1);

      // CTR_INIT 3, CTR_WAIT, DONE
      clear_rom();
      rom[0] = ent(4'd4, 80'h3); rom[1] = ent(4'd5, 80'h0);
      do_reset();
      if (ctr_en) begin
         tick();
         chk("seq4 addr after init", 128'(rom_addr_o), 1);
         for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("seq4 wait addr c%0d", c), 128'(rom_addr_o), 1);
         end
         tick();
         chk("seq4 addr after wait", 128'(rom_addr_o), 2);
         chk("seq4 error", 128'(error_o), 0);
         tick();
         chk("seq4 done", 128'(done_o), 1);
      end else begin
         tick();
         chk("seq4 error no ctr", 128'(error_o), 1);
         tick();
         chk("seq4 addr no ctr", 128'(rom_addr_o), 0);
      end

      // en_i low freezes a SEND
      clear_rom();
      rom[0] = ent(4'd0, 80'h1);
      en_i = 0; yumi_i = 1;
      do_reset();
      tick(); tick();
      chk("seq5 en0 v_o", 128'(v_o), 0);
      chk("seq5 en0 addr", 128'(rom_addr_o), 0);
      yumi_i = 0; en_i = 1;

      // asynchronous reset mid-trace with done and error both set
      clear_rom();
      rom[0] = ent(4'd1, 80'h1);
      v_i = 1; data_i = 80'h2;
      do_reset();
      tick();
      v_i = 0;
      tick();
      chk("seq6 pre addr", 128'(rom_addr_o), 1);
      chk("seq6 pre done", 128'(done_o), 1);
      chk("seq6 pre error", 128'(error_o), 1);
      #2 reset_i = 0;
      #1;
      chk("seq6 async addr", 128'(rom_addr_o), 0);
      chk("seq6 async done", 128'(done_o), 0);
      chk("seq6 async error", 128'(error_o), 0);
      chk("seq6 entry0 ready", 128'(ready_and_o), 1);
      tick();
      chk("seq6 held addr", 128'(rom_addr_o), 0);
      reset_i = 1;
      #1;
      chk("seq6 restart ready", 128'(ready_and_o), 1);
      chk("seq6 restart data_o", 128'(data_o), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: actual running, required finished");
      $fatal(1);
   end
endmodule

// File: doc/fsb_node_trace_replay.md
FSB_NODE_TRACE_REPLAY -- requirements
Module: fsb_node_trace_replay

Interface
REQ-001 Parameter ring_width_p, default 80: payload width of a trace entry.
REQ-002 Parameter rom_addr_width_p, default 23: trace ROM address width.
REQ-003 Parameter counter_width_p, default 32: cycle-counter width, must be <= ring_width_p.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 en_i  in  1  global enable; 0 freezes replay.
REQ-007 v_i  in  1  inbound data valid.
REQ-008 data_i  in  ring_width_p  inbound data compared against expected.
REQ-009 ready_and_o  out  1  replay accepts inbound data this cycle.
REQ-010 v_o  out  1  outbound data valid.
REQ-011 data_o  out  ring_width_p  outbound payload.
REQ-012 yumi_i  in  1  consumer takes data_o this cycle; legal only while v_o=1.
REQ-013 rom_addr_o  out  rom_addr_width_p  current trace entry address.
REQ-014 rom_data_i  in  ring_width_p+4  entry at rom_addr_o, combinational (same-cycle) ROM.
REQ-015 done_o  out  1  trace reached done/finish entry.
REQ-016 error_o  out  1  sticky mismatch/illegal-op flag.

Function
REQ-017 Entry decode: op = rom_data_i[ring_width_p+3:ring_width_p], payload = rom_data_i[ring_width_p-1:0].
REQ-018 data_o SHALL equal payload at all times, independent of op.
REQ-019 Advance means rom_addr_o increments by 1 at the next edge, wrapping from all-ones to 0.
REQ-020 en_i=0: v_o=0, ready_and_o=0, no advance, counter and flags hold.
REQ-021 op 0 SEND: v_o=1; advance on the cycle yumi_i=1; otherwise hold.
REQ-022 op 1 RECV: ready_and_o=1; on v_i=1 advance, and if data_i != payload set error flag at the same edge.
REQ-023 op 2 DONE and op 3 FINISH: set done flag; never advance; v_o=0, ready_and_o=0.
REQ-024 op 4 CTR_INIT: load counter with payload[counter_width_p-1:0]; advance.
REQ-025 op 5 CTR_WAIT: counter != 0 -> decrement, hold; counter == 0 -> advance.
REQ-026 op 6 NOP: advance unconditionally.
REQ-027 Any other op: set error flag; hold (no advance); v_o=0, ready_and_o=0.
REQ-028 error_o and done_o are registered and sticky until reset; error does not stop replay of legal entries.
REQ-029 Throughput: at most one entry retired per cycle; SEND/RECV retire in the handshake cycle with zero added latency.

Reset
REQ-030 While reset_i=0: rom_addr_o=0, counter=0, done_o=0, error_o=0, regardless of clock.
REQ-031 Reset deassertion mid-trace restarts replay from address 0; v_o/ready_and_o follow decode of entry 0 combinationally.

Configuration
REQ-032 Macro FSB_TRACE_CYCLE_CTR_EN defined: ops 4 and 5 behave per REQ-024/REQ-025.
REQ-033 Macro undefined: counter register absent; ops 4 and 5 treated as illegal per REQ-027.

Verification
REQ-034 Entries SEND 0x5, SEND 0x6, DONE; yumi_i held 1 -> v_o=1 with data_o 0x5 then 0x6 on consecutive cycles; done_o=1 from the cycle after address 2 is reached; rom_addr_o stays 2.
REQ-035 SEND 0xA with yumi_i=0 for 5 cycles then 1 -> rom_addr_o holds 0 for 5 cycles, advances to 1 after the yumi cycle.
REQ-036 RECV 0x3 with data_i=0x3, then RECV 0x4 with data_i=0x7 -> error_o=0 after first, error_o=1 after second and stays 1; address advances both times.
REQ-037 CTR_INIT 3, CTR_WAIT, DONE (macro defined) -> address sits on CTR_WAIT 4 cycles, then reaches DONE; macro undefined -> error_o=1, address stuck at 0.
REQ-038 Op 0xF at address 0 -> error_o=1 next cycle, rom_addr_o stays 0; en_i=0 with SEND entry -> v_o=0, no advance.
REQ-039 Assert reset_i=0 asynchronously mid-trace with done_o=1 -> rom_addr_o, done_o, error_o clear immediately, without a clock edge.
